// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU header: writeback-bus layout and register-file geometry.
package regfile_scoreboard_pkg;

    localparam int WS_TO_RF_BUS_WD = 38;
    localparam int WS_WE_BIT       = 37;
    localparam int WS_WADDR_HI     = 36;
    localparam int WS_WADDR_LO     = 32;
    localparam int WS_WDATA_HI     = 31;
    localparam int WS_WDATA_LO     = 0;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int REG_W    = 32;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 general register file: one synchronous write port, two combinational
// read ports with same-cycle writeback bypass. r0 is hardwired to zero.
module regfile_2r1w
    import regfile_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [REG_W-1:0]  wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [REG_W-1:0]  rdata1,
    output logic [REG_W-1:0]  rdata2
);

    logic [REG_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0)              ? '0    :
                    (we && waddr == raddr1)     ? wdata :
                                                  regs[raddr1];
    assign rdata2 = (raddr2 == '0)              ? '0    :
                    (we && waddr == raddr2)     ? wdata :
                                                  regs[raddr2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file plus per-register pending-write scoreboard; raises the
// read-after-write stall to decode until the producer has written back.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int WS_TO_RF_BUS_WD = regfile_scoreboard_pkg::WS_TO_RF_BUS_WD,
    parameter int CNT_W           = 2,
    parameter int CNT_MAX         = 3
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    input  logic [REG_AW-1:0]          raddr1,
    input  logic [REG_AW-1:0]          raddr2,
    output logic [REG_W-1:0]           rdata1,
    output logic [REG_W-1:0]           rdata2,
    input  logic                       ds_check_valid,
    input  logic                       ds_src1_used,
    input  logic                       ds_src2_used,
    input  logic                       ds_issue,
    input  logic                       ds_issue_we,
    input  logic [REG_AW-1:0]          ds_issue_dest,
    input  logic                       sb_flush,
    output logic                       ds_raw_stall,
    output logic [NUM_REGS-1:0]        sb_busy,
    output logic                       sb_error
);

    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic              ws_we;
    logic [REG_AW-1:0] ws_waddr;
    logic [REG_W-1:0]  ws_wdata;

    assign ws_we    = ws_to_rf_bus[WS_WE_BIT];
    assign ws_waddr = ws_to_rf_bus[WS_WADDR_HI:WS_WADDR_LO];
    assign ws_wdata = ws_to_rf_bus[WS_WDATA_HI:WS_WDATA_LO];

    regfile_2r1w u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (ws_we),
        .waddr  (ws_waddr),
        .wdata  (ws_wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                overflow;
    logic                underflow;

    always_comb begin
        inc       = '0;
        dec       = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            inc[i] = ds_issue && ds_issue_we && (ds_issue_dest == REG_AW'(i));
            dec[i] = ws_we && (ws_waddr == REG_AW'(i));
            if (inc[i] && !dec[i] && cnt[i] == CNT_MAX_V) overflow  = 1'b1;
            if (dec[i] && !inc[i] && cnt[i] == '0)        underflow = 1'b1;
        end
    end

    // Flush wins over inc/dec, so a flush cycle can never flag an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            sb_error <= 1'b0;
        end else begin
            if (!sb_flush && (overflow || underflow)) sb_error <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sb_flush || i == 0) begin
                    cnt[i] <= '0;
                end else if (inc[i] && !dec[i] && cnt[i] != CNT_MAX_V) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec[i] && !inc[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // A last pending producer writing back this cycle is covered by the bypass.
    function automatic logic busy_eff(input logic [CNT_W-1:0]  c,
                                      input logic [REG_AW-1:0] a,
                                      input logic              we,
                                      input logic [REG_AW-1:0] wa);
        return (c != '0) && !(c == CNT_ONE && we && wa == a);
    endfunction

    assign ds_raw_stall = ds_check_valid &&
        ((ds_src1_used && raddr1 != '0 && busy_eff(cnt[raddr1], raddr1, ws_we, ws_waddr)) ||
         (ds_src2_used && raddr2 != '0 && busy_eff(cnt[raddr2], raddr2, ws_we, ws_waddr)));

    always_comb begin
        sb_busy = '0;
        for (int i = 1; i < NUM_REGS; i++) sb_busy[i] = (cnt[i] != '0);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations,
// then randomized in-order issue/writeback traffic against a behavioural model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_we;
    logic [4:0]  bus_waddr;
    logic [31:0] bus_wdata;
    logic [37:0] ws_to_rf_bus;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ds_check_valid, ds_src1_used, ds_src2_used;
    logic        ds_issue, ds_issue_we;
    logic [4:0]  ds_issue_dest;
    logic        sb_flush;
    logic        ds_raw_stall;
    logic [31:0] sb_busy;
    logic        sb_error;

    assign ws_to_rf_bus = {bus_we, bus_waddr, bus_wdata};

    regfile_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .ws_to_rf_bus   (ws_to_rf_bus),
        .raddr1         (raddr1),
        .raddr2         (raddr2),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .ds_check_valid (ds_check_valid),
        .ds_src1_used   (ds_src1_used),
        .ds_src2_used   (ds_src2_used),
        .ds_issue       (ds_issue),
        .ds_issue_we    (ds_issue_we),
        .ds_issue_dest  (ds_issue_dest),
        .sb_flush       (sb_flush),
        .ds_raw_stall   (ds_raw_stall),
        .sb_busy        (sb_busy),
        .sb_error       (sb_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register values, pending counts, sticky error.
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_err;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] <= '0;
                m_cnt[i] <= 0;
            end
            m_err       <= 1'b0;
            model_valid <= 1'b1;
        end else begin
            if (bus_we && bus_waddr != 0) m_reg[bus_waddr] <= bus_wdata;
            if (sb_flush) begin
                for (int i = 0; i < 32; i++) m_cnt[i] <= 0;
            end else begin
                for (int i = 1; i < 32; i++) begin
                    bit up, down;
                    up   = ds_issue && ds_issue_we && (int'(ds_issue_dest) == i);
                    down = bus_we && (int'(bus_waddr) == i);
                    if (up && !down) begin
                        if (m_cnt[i] == 3) m_err <= 1'b1;
                        else               m_cnt[i] <= m_cnt[i] + 1;
                    end else if (down && !up) begin
                        if (m_cnt[i] == 0) m_err <= 1'b1;
                        else               m_cnt[i] <= m_cnt[i] - 1;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus_we && bus_waddr == a) return bus_wdata;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy_eff(input logic [4:0] a);
        return (m_cnt[a] != 0) && !(m_cnt[a] == 1 && bus_we && bus_waddr == a);
    endfunction

    function automatic bit exp_stall();
        return ds_check_valid &&
            ((ds_src1_used && raddr1 != 0 && exp_busy_eff(raddr1)) ||
             (ds_src2_used && raddr2 != 0 && exp_busy_eff(raddr2)));
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            chk("rdata1",       rdata1,       exp_rd(raddr1));
            chk("rdata2",       rdata2,       exp_rd(raddr2));
            chk("ds_raw_stall", 32'(ds_raw_stall), 32'(exp_stall()));
            chk("sb_busy",      sb_busy,      exp_busy());
            chk("sb_error",     32'(sb_error), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset          = 1'b0;
        bus_we         = 1'b0;
        bus_waddr      = '0;
        bus_wdata      = '0;
        raddr1         = '0;
        raddr2         = '0;
        ds_check_valid = 1'b0;
        ds_src1_used   = 1'b0;
        ds_src2_used   = 1'b0;
        ds_issue       = 1'b0;
        ds_issue_we    = 1'b0;
        ds_issue_dest  = '0;
        sb_flush       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] dest);
        ds_issue      = 1'b1;
        ds_issue_we   = 1'b1;
        ds_issue_dest = dest;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus_we    = 1'b1;
        bus_waddr = a;
        bus_wdata = d;
    endtask

    int q[$];

    initial begin
        idle();
        do_reset();

        // Reset state
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            chk("reset_rdata1", rdata1, 32'h0);
            chk("reset_rdata2", rdata2, 32'h0);
        end
        chk("reset_busy", sb_busy, 32'h0);
        chk("reset_stall", 32'(ds_raw_stall), 32'h0);
        chk("reset_error", 32'(sb_error), 32'h0);

        // Bypass then array read; r0 write dropped
        idle();
        wb(5'd3, 32'hDEADBEEF);
        raddr1 = 5'd3;
        #1 chk("bypass_r3", rdata1, 32'hDEADBEEF);
        step();
        bus_we = 1'b0;
        #1 chk("array_r3", rdata1, 32'hDEADBEEF);
        wb(5'd0, 32'h1234);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1 chk("r0_bypass", rdata1, 32'h0);
        step();
        bus_we = 1'b0;
        #1 chk("r0_array", rdata2, 32'h0);

        // Single producer to r7
        idle();
        issue(5'd7);
        step();
        idle();
        ds_check_valid = 1'b1;
        ds_src1_used   = 1'b1;
        raddr1         = 5'd7;
        #1 chk("r7_stall", 32'(ds_raw_stall), 32'h1);
        chk("r7_busy", 32'(sb_busy[7]), 32'h1);
        step();
        #1 chk("r7_stall_held", 32'(ds_raw_stall), 32'h1);
        wb(5'd7, 32'h55);
        #1 chk("r7_wb_stall", 32'(ds_raw_stall), 32'h0);
        chk("r7_wb_rdata", rdata1, 32'h55);
        step();
        bus_we = 1'b0;
        #1 chk("r7_busy_clear", 32'(sb_busy[7]), 32'h0);

        // Two producers to r9
        idle();
        issue(5'd9);
        step();
        step();
        idle();
        ds_check_valid = 1'b1;
        ds_src2_used   = 1'b1;
        raddr2         = 5'd9;
        #1 chk("r9_stall2", 32'(ds_raw_stall), 32'h1);
        wb(5'd9, 32'h9);
        #1 chk("r9_first_wb_stall", 32'(ds_raw_stall), 32'h1);
        step();
        #1 chk("r9_cnt1_busy", 32'(sb_busy[9]), 32'h1);
        wb(5'd9, 32'h99);
        #1 chk("r9_second_wb_stall", 32'(ds_raw_stall), 32'h0);
        step();
        bus_we = 1'b0;
        #1 chk("r9_busy_clear", 32'(sb_busy[9]), 32'h0);

        // Simultaneous inc/dec on r4, then saturation on r5
        idle();
        issue(5'd4);
        step();
        wb(5'd4, 32'h4);
        step();
        idle();
        #1 chk("r4_inc_dec_busy", 32'(sb_busy[4]), 32'h1);
        wb(5'd4, 32'h44);
        step();
        idle();
        #1 chk("r4_drained", 32'(sb_busy[4]), 32'h0);
        issue(5'd5);
        for (int k = 0; k < 4; k++) step();
        idle();
        #1 chk("r5_overflow_error", 32'(sb_error), 32'h1);
        chk("r5_busy", 32'(sb_busy[5]), 32'h1);

        // Flush, then a stray writeback underflows
        do_reset();
        issue(5'd10);
        step();
        issue(5'd11);
        step();
        idle();
        #1 chk("pre_flush_busy", sb_busy, 32'h0000_0C00);
        sb_flush = 1'b1;
        step();
        idle();
        ds_check_valid = 1'b1;
        ds_src1_used   = 1'b1;
        raddr1         = 5'd10;
        #1 chk("flush_busy", sb_busy, 32'h0);
        chk("flush_stall", 32'(ds_raw_stall), 32'h0);
        chk("flush_error", 32'(sb_error), 32'h0);
        wb(5'd10, 32'h77);
        step();
        bus_we = 1'b0;
        #1 chk("stray_underflow", 32'(sb_error), 32'h1);
        chk("stray_written", rdata1, 32'h77);

        // Randomized in-order pipeline traffic
        do_reset();
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                q.delete();
            end
            sb_flush  = ($urandom_range(0, 49) == 0);
            bus_wdata = $urandom;
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus_we    = 1'b1;
                bus_waddr = 5'(q.pop_front());
            end else if ($urandom_range(0, 199) == 0) begin
                bus_we    = 1'b1;
                bus_waddr = 5'($urandom_range(0, 31));
            end
            ds_check_valid = $urandom_range(0, 3) != 0;
            ds_src1_used   = $urandom_range(0, 1);
            ds_src2_used   = $urandom_range(0, 1);
            raddr1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            raddr2 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ds_issue_we   = $urandom_range(0, 3) != 0;
            ds_issue_dest = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ds_issue = ds_check_valid && !exp_stall() && q.size() < 3 && $urandom_range(0, 1) == 1;
            if (ds_issue && ds_issue_we) q.push_back(int'(ds_issue_dest));
            if (sb_flush || reset) q.delete();
            step();
        end

        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Receiving end of the writeback-to-register-file bus. Holds the 32x32 general register file and consumes the write bus.
- Provides two combinational read ports to the decode stage, with same-cycle writeback bypass.
- Tracks in-flight destination writes per register (scoreboard). Raises a read-after-write stall to decode until the producing instruction has written back.

Parameters:
- WS_TO_RF_BUS_WD, 38, width of the writeback bus: {we[37], waddr[36:32], wdata[31:0]}
- CNT_W, 2, width of each per-register pending-write counter
- CNT_MAX, 3, saturation value of the pending counter; equals the maximum instructions in flight between issue and writeback

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ws_to_rf_bus  input  WS_TO_RF_BUS_WD  writeback bus; we already qualified by writeback valid
- raddr1  input  5  read port 1 address
- raddr2  input  5  read port 2 address
- rdata1  output  32  read port 1 data
- rdata2  output  32  read port 2 data
- ds_check_valid  input  1  decode holds a valid instruction whose sources are being checked
- ds_src1_used  input  1  instruction reads raddr1
- ds_src2_used  input  1  instruction reads raddr2
- ds_issue  input  1  instruction leaves decode this cycle (valid && ready_go && downstream allowin)
- ds_issue_we  input  1  issuing instruction writes a GPR
- ds_issue_dest  input  5  issuing instruction's destination
- sb_flush  input  1  discard all in-flight tracking (pipeline flush)
- ds_raw_stall  output  1  decode must not proceed
- sb_busy  output  32  bit i = pending counter of register i nonzero (debug/verification)
- sb_error  output  1  sticky: counter overflow or underflow occurred

Behaviour:
- Reset:
  - All 32 registers clear to 0.
  - All counters clear to 0; sb_error = 0.
  - Outputs are combinational from this state: rdata = 0, ds_raw_stall = 0, sb_busy = 0.
- Write, 1-cycle latency:
  - At posedge, if we && waddr != 0, then reg[waddr] <= wdata.
  - Writes to r0 are dropped; r0 always reads 0.
- Read, combinational, 0 latency; per port:
  - raddr == 0 -> 0
  - else if we && waddr == raddr -> wdata (bypass)
  - else reg[raddr]
- Counter update, per register i, each cycle:
  - inc_i = ds_issue && ds_issue_we && ds_issue_dest == i && i != 0
  - dec_i = we && waddr == i && i != 0
  - inc and dec both set: counter unchanged.
  - inc only: +1. If already CNT_MAX, hold and set sb_error.
  - dec only: -1. If already 0, hold and set sb_error.
  - Counter 0 never changes; it reads as 0.
- Flush:
  - sb_flush clears all counters at the next posedge and takes priority over inc/dec in that cycle.
  - The register write in the same cycle still occurs.
  - sb_error is not cleared by flush, only by reset.
- Effective busy, per source address a:
  - busy_eff(a) = cnt[a] != 0 && !(cnt[a] == 1 && we && waddr == a)
  - The writeback of the last pending producer is covered by the bypass, so no stall.
- Stall:
  - ds_raw_stall = ds_check_valid && ((ds_src1_used && raddr1 != 0 && busy_eff(raddr1)) || (ds_src2_used && raddr2 != 0 && busy_eff(raddr2)))
  - Purely combinational; no registered stall.
  - Decode must not assert ds_issue while ds_raw_stall = 1. The block does not enforce this.
- Self-dependency: an instruction whose dest equals its own source checks the old counter; its own issue increments only after the edge.
- sb_busy[i] = cnt[i] != 0; sb_busy[0] = 0.
- Reset mid-operation: all pending tracking is lost and registers clear. The upstream pipeline resets in the same cycle, so no late writebacks arrive.

Decomposition:
- Shared header (existing CPU head file) holds WS_TO_RF_BUS_WD and the bus bit-field positions.
- Natural sub-module: regfile_2r1w (array, write, bypassed reads).
- Scoreboard counters and stall logic stay in the top.

Test Plan:
- Reset then read r0..r31 -> all 0; sb_busy = 0; ds_raw_stall = 0.
- Write bus {1, 5'd3, 32'hDEADBEEF}, raddr1 = 3 same cycle -> rdata1 = 32'hDEADBEEF (bypass); next cycle still 32'hDEADBEEF from the array. Write r0 with 32'h1234 -> r0 reads 0.
- Issue dest=7; next cycle check with raddr1 = 7, src1_used -> stall = 1. Stall held until the cycle writeback writes r7 with 32'h55, where stall = 0 and rdata1 = 32'h55; sb_busy[7] = 0 afterwards.
- Two issues to dest=9 (cnt = 2); first writeback of r9 -> stall still 1 that cycle and cnt = 1; second writeback -> stall 0, cnt = 0.
- Same cycle: issue dest=4 and writeback r4 with cnt[4] = 1 -> cnt stays 1, sb_busy[4] = 1. Four issues to r5 with no writeback -> cnt saturates at 3, sb_error = 1.
- Issue to r10 and r11, then sb_flush -> next cycle sb_busy = 0, stall 0 on r10. A later stray writeback to r10 -> sb_error = 1 (underflow) and r10 is still written.
